// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order fetch-to-dispatch circular queue. Fetch lanes are compacted
// into the ring at tail, dispatch drains a prefix of the oldest entries by take count,
// a branch flush squashes everything, and occupancy is exported for fetch throttling.

package dispatch_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } fetch_dispatch_packet_t;
endpackage

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned IN_WAYS  = 2,
  parameter int unsigned OUT_WAYS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            branch_flush_en,
  input  fetch_dispatch_packet_t          fetch_in [IN_WAYS],
  output logic [$clog2(IN_WAYS+1)-1:0]    in_accept_lanes,
  output logic                            in_stall,
  output fetch_dispatch_packet_t          dispatch_out [OUT_WAYS],
  input  logic [$clog2(OUT_WAYS+1)-1:0]   out_take_cnt,
  output logic [CNT_BITS-1:0]             occupancy,
  output logic [CNT_BITS-1:0]             free_slots
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AccW = $clog2(IN_WAYS + 1);

  // Ring pointer advance; n never exceeds DEPTH so one subtraction suffices.
  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] ptr,
                                               input int unsigned n);
    int unsigned sum;
    sum = 32'(ptr) + n;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PtrW'(sum);
  endfunction

  fetch_dispatch_packet_t entries_q [DEPTH];
  logic [PtrW-1:0]        head_q, head_d;
  logic [PtrW-1:0]        tail_q, tail_d;
  logic [CNT_BITS-1:0]    count_q, count_d;

  logic                   active;
  int unsigned            acc_cnt;
  int unsigned            accept_idx;
  logic [IN_WAYS-1:0]     lane_wr;
  logic [PtrW-1:0]        lane_ptr [IN_WAYS];
  int unsigned            avail_cnt;
  int unsigned            take_cnt;

  // Reset and flush both suppress all handshakes in the current cycle.
  assign active = reset_n && !branch_flush_en;

  // Enqueue scan: valid lanes take free slots in order, holes are skipped, and the
  // first valid lane without a slot blocks itself and every later lane.
  always_comb begin
    int unsigned free_cnt;
    logic        blocked;
    free_cnt   = DEPTH - 32'(count_q);
    acc_cnt    = 0;
    accept_idx = IN_WAYS;
    blocked    = 1'b0;
    for (int i = 0; i < IN_WAYS; i++) begin
      lane_wr[i]  = 1'b0;
      lane_ptr[i] = wrap_add(tail_q, acc_cnt);
      if (active && fetch_in[i].valid && !blocked) begin
        if (acc_cnt < free_cnt) begin
          lane_wr[i] = 1'b1;
          acc_cnt    = acc_cnt + 1;
        end else begin
          blocked    = 1'b1;
          accept_idx = i;
        end
      end
    end
  end

  // Dispatch consumption, clamped to the lanes actually offered.
  always_comb begin
    avail_cnt = (32'(count_q) < OUT_WAYS) ? 32'(count_q) : OUT_WAYS;
    take_cnt  = (32'(out_take_cnt) < avail_cnt) ? 32'(out_take_cnt) : avail_cnt;
  end

  // Pointer and count next state; flush discards queue contents and incoming lanes.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (branch_flush_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = wrap_add(head_q, take_cnt);
      tail_d  = wrap_add(tail_q, acc_cnt);
      count_d = CNT_BITS'(32'(count_q) + acc_cnt - take_cnt);
    end
  end

  // State registers and entry writes; reset overrides every other update.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < IN_WAYS; i++) begin
        if (lane_wr[i]) entries_q[lane_ptr[i]] <= fetch_in[i];
      end
    end
  end

  // Oldest entries on the dispatch lanes; no bypass from fetch.
  always_comb begin
    for (int i = 0; i < OUT_WAYS; i++) begin
      dispatch_out[i]       = entries_q[wrap_add(head_q, i)];
      dispatch_out[i].valid = active && (i < 32'(count_q));
    end
  end

  // Fetch handshake and occupancy outputs, forced quiet while reset is asserted.
  always_comb begin
    in_accept_lanes = active ? AccW'(accept_idx) : '0;
    in_stall        = active && (accept_idx < IN_WAYS);
    occupancy       = reset_n ? count_q : '0;
    free_slots      = reset_n ? CNT_BITS'(DEPTH - 32'(count_q)) : CNT_BITS'(DEPTH);
  end

  count_bound_a : assert property (@(posedge clock) disable iff (!reset_n)
    32'(count_q) <= DEPTH);
  tail_track_a : assert property (@(posedge clock) disable iff (!reset_n)
    tail_q == wrap_add(head_q, 32'(count_q)));

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: a vector table on a 2/2/8 instance plus short
// hand-written sequences for reset release and a 4/3/6 instance.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: IN_WAYS=2, OUT_WAYS=2, DEPTH=8
  logic                   rst_a, flush_a;
  fetch_dispatch_packet_t fetch_a [2];
  logic [1:0]             acc_a;
  logic                   stall_a;
  fetch_dispatch_packet_t disp_a [2];
  logic [1:0]             take_a;
  logic [3:0]             occ_a, free_a;

  // Instance B: IN_WAYS=4, OUT_WAYS=3, DEPTH=6
  logic                   rst_b, flush_b;
  fetch_dispatch_packet_t fetch_b [4];
  logic [2:0]             acc_b;
  logic                   stall_b;
  fetch_dispatch_packet_t disp_b [3];
  logic [1:0]             take_b;
  logic [2:0]             occ_b, free_b;

  dispatch_queue #(.IN_WAYS(2), .OUT_WAYS(2), .DEPTH(8)) dut_a (
    .clock(clk), .reset_n(rst_a), .branch_flush_en(flush_a), .fetch_in(fetch_a),
    .in_accept_lanes(acc_a), .in_stall(stall_a), .dispatch_out(disp_a),
    .out_take_cnt(take_a), .occupancy(occ_a), .free_slots(free_a)
  );

  dispatch_queue #(.IN_WAYS(4), .OUT_WAYS(3), .DEPTH(6)) dut_b (
    .clock(clk), .reset_n(rst_b), .branch_flush_en(flush_b), .fetch_in(fetch_b),
    .in_accept_lanes(acc_b), .in_stall(stall_b), .dispatch_out(disp_b),
    .out_take_cnt(take_b), .occupancy(occ_b), .free_slots(free_b)
  );

  typedef struct {
    logic        rstn;
    logic        flush;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    int          take;
    logic        ca;     // check in_accept_lanes this row
    int          acc;
    logic        stall;
    int          occ;
    logic        ov0;
    logic [31:0] od0;
    logic        ov1;
    logic [31:0] od1;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(logic rstn, logic flush, logic v0, logic [31:0] d0, logic v1,
                              logic [31:0] d1, int take, logic ca, int acc, logic stall,
                              int occ, logic ov0, logic [31:0] od0, logic ov1,
                              logic [31:0] od1);
    vec_t v;
    v = '{rstn, flush, v0, d0, v1, d1, take, ca, acc, stall, occ, ov0, od0, ov1, od1};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; flush_a = 1'b0; take_a = '0;
    rst_b = 1'b0; flush_b = 1'b0; take_b = '0;
    for (int i = 0; i < 2; i++) fetch_a[i] = '0;
    for (int i = 0; i < 4; i++) fetch_b[i] = '0;

    //        rst flu v0 d0     v1 d1     tk ca acc st occ ov0 od0    ov1 od1
    vecs.push_back(mk(1, 0, 1, 'hA1, 1, 'hB2, 0, 1, 2, 0, 0, 0, 0, 0, 0));     // basic
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2, 1, 2, 0, 2, 1, 'hA1, 1, 'hB2));
    vecs.push_back(mk(1, 0, 0, 'hEE, 1, 'hC3, 0, 1, 2, 0, 0, 0, 0, 0, 0));    // hole
    vecs.push_back(mk(1, 0, 1, 'h11, 1, 'h12, 0, 1, 2, 0, 1, 1, 'hC3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 'h13, 1, 'h14, 0, 1, 2, 0, 3, 1, 'hC3, 1, 'h11));
    vecs.push_back(mk(1, 0, 1, 'h15, 0, 0, 0, 1, 2, 0, 5, 1, 'hC3, 1, 'h11));
    vecs.push_back(mk(1, 0, 1, 'h16, 0, 0, 0, 1, 2, 0, 6, 1, 'hC3, 1, 'h11));
    vecs.push_back(mk(1, 0, 1, 'hD4, 1, 'hE5, 1, 1, 1, 1, 7, 1, 'hC3, 1, 'h11)); // bp
    vecs.push_back(mk(1, 0, 1, 'hE5, 0, 0, 0, 1, 2, 0, 7, 1, 'h11, 1, 'h12));
    vecs.push_back(mk(1, 0, 1, 'h99, 1, 'h9A, 0, 1, 0, 1, 8, 1, 'h11, 1, 'h12)); // full
    vecs.push_back(mk(1, 0, 0, 0, 1, 'h9A, 2, 1, 1, 1, 8, 1, 'h11, 1, 'h12));
    vecs.push_back(mk(1, 0, 1, 'h20, 1, 'h21, 2, 1, 2, 0, 6, 1, 'h13, 1, 'h14)); // wrap
    vecs.push_back(mk(1, 0, 1, 'h22, 1, 'h23, 2, 1, 2, 0, 6, 1, 'h15, 1, 'h16));
    vecs.push_back(mk(1, 0, 1, 'h24, 1, 'h25, 2, 1, 2, 0, 6, 1, 'hD4, 1, 'hE5));
    vecs.push_back(mk(1, 0, 1, 'h26, 1, 'h27, 2, 1, 2, 0, 6, 1, 'h20, 1, 'h21));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 6, 1, 'h22, 1, 'h23));
    vecs.push_back(mk(1, 1, 1, 'hF6, 1, 'hF7, 2, 1, 0, 0, 5, 0, 0, 0, 0));    // flush
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 'h30, 1, 'h31, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 'h32, 1, 'h33, 0, 1, 2, 0, 2, 1, 'h30, 1, 'h31));
    vecs.push_back(mk(1, 0, 1, 'h34, 1, 'h35, 0, 1, 2, 0, 4, 1, 'h30, 1, 'h31));
    vecs.push_back(mk(0, 1, 1, 'h36, 1, 'h37, 0, 1, 0, 0, 0, 0, 0, 0, 0));    // reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 'h40, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2, 0, 1, 1, 'h40, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk("a_post_reset.occ", 32'(occ_a), 0);
    chk("a_post_reset.free", 32'(free_a), 8);
    chk("a_post_reset.stall", 32'(stall_a), 0);
    chk("a_post_reset.ov0", 32'(disp_a[0].valid), 0);
    chk("a_post_reset.ov1", 32'(disp_a[1].valid), 0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      rst_a      = v.rstn;
      flush_a    = v.flush;
      fetch_a[0] = '{valid: v.v0, instr: v.d0};
      fetch_a[1] = '{valid: v.v1, instr: v.d1};
      take_a     = 2'(v.take);
      @(negedge clk);
      if (v.rstn && !v.flush)
        assert (v.take <= int'(v.ov0) + int'(v.ov1)) else $error("illegal take in row %0d", i);
      if (v.ca) chk($sformatf("v%0d.acc", i), 32'(acc_a), 32'(v.acc));
      chk($sformatf("v%0d.stall", i), 32'(stall_a), 32'(v.stall));
      chk($sformatf("v%0d.occ", i), 32'(occ_a), 32'(v.occ));
      chk($sformatf("v%0d.free", i), 32'(free_a), 32'(8 - v.occ));
      chk($sformatf("v%0d.ov0", i), 32'(disp_a[0].valid), 32'(v.ov0));
      chk($sformatf("v%0d.ov1", i), 32'(disp_a[1].valid), 32'(v.ov1));
      if (v.ov0) chk($sformatf("v%0d.od0", i), disp_a[0].instr, v.od0);
      if (v.ov1) chk($sformatf("v%0d.od1", i), disp_a[1].instr, v.od1);
      step();
    end
    rst_a = 1'b1; flush_a = 1'b0; take_a = '0;
    fetch_a[0] = '0; fetch_a[1] = '0;

    // Instance B: reset, basic enqueue with wider fetch, then fill to full.
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_reset.occ", 32'(occ_b), 0);
    chk("b_reset.free", 32'(free_b), 6);
    chk("b_reset.ov0", 32'(disp_b[0].valid), 0);
    step();
    fetch_b[0] = '{valid: 1'b1, instr: 32'hA0};
    fetch_b[1] = '{valid: 1'b1, instr: 32'hB0};
    @(negedge clk);
    chk("b_enq.acc", 32'(acc_b), 4);
    chk("b_enq.stall", 32'(stall_b), 0);
    chk("b_enq.ov0", 32'(disp_b[0].valid), 0);
    step();
    fetch_b[0] = '{valid: 1'b1, instr: 32'hC0};
    fetch_b[1] = '{valid: 1'b1, instr: 32'hD0};
    fetch_b[2] = '{valid: 1'b1, instr: 32'hE0};
    fetch_b[3] = '{valid: 1'b1, instr: 32'hF0};
    @(negedge clk);
    chk("b_out.occ", 32'(occ_b), 2);
    chk("b_out.free", 32'(free_b), 4);
    chk("b_out.od0", disp_b[0].instr, 32'hA0);
    chk("b_out.od1", disp_b[1].instr, 32'hB0);
    chk("b_out.ov1", 32'(disp_b[1].valid), 1);
    chk("b_out.ov2", 32'(disp_b[2].valid), 0);
    chk("b_fill.acc", 32'(acc_b), 4);
    step();
    fetch_b[0] = '{valid: 1'b1, instr: 32'h10};
    fetch_b[1] = '{valid: 1'b1, instr: 32'h11};
    fetch_b[2] = '0;
    fetch_b[3] = '0;
    @(negedge clk);
    chk("b_full.acc", 32'(acc_b), 0);
    chk("b_full.stall", 32'(stall_b), 1);
    chk("b_full.occ", 32'(occ_b), 6);
    chk("b_full.free", 32'(free_b), 0);
    chk("b_full.od2", disp_b[2].instr, 32'hC0);
    chk("b_full.ov2", 32'(disp_b[2].valid), 1);
    step();
    fetch_b[0] = '0;
    fetch_b[1] = '0;
    take_b = 2'd3;
    @(negedge clk);
    chk("b_take.acc", 32'(acc_b), 4);
    chk("b_take.od0", disp_b[0].instr, 32'hA0);
    step();
    take_b = 2'd0;
    @(negedge clk);
    chk("b_after.occ", 32'(occ_b), 3);
    chk("b_after.od0", disp_b[0].instr, 32'hD0);
    chk("b_after.od1", disp_b[1].instr, 32'hE0);
    chk("b_after.od2", disp_b[2].instr, 32'hF0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
